// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcode constants, control-word bit map and encodings for decode_queue
package decode_pkg;

  localparam int CTRL_W = 34;

  localparam int C_REGWRITE     = 0;
  localparam int C_REGDST       = 1;
  localparam int C_ALUSRC       = 2;
  localparam int C_BRANCH       = 3;
  localparam int C_BAL          = 4;
  localparam int C_JAL          = 5;
  localparam int C_JR           = 6;
  localparam int C_JALR         = 7;
  localparam int C_JUMP         = 8;
  localparam int C_MEMWRITE_LSB = 9;
  localparam int C_MEMWRITE_MSB = 12;
  localparam int C_MEMREAD_LSB  = 13;
  localparam int C_MEMREAD_MSB  = 16;
  localparam int C_MEMSIGN      = 17;
  localparam int C_MEMTOREG     = 18;
  localparam int C_HILOWRITE    = 19;
  localparam int C_REGTOHILO_HI = 20;
  localparam int C_REGTOHILO_LO = 21;
  localparam int C_MDTOHILO     = 22;
  localparam int C_MULORDIV     = 23;
  localparam int C_MDSIGN       = 24;
  localparam int C_HILOTOREG    = 25;
  localparam int C_HILOSRC      = 26;
  localparam int C_WRITECP0     = 27;
  localparam int C_CP0TOREG     = 28;
  localparam int C_EX_RI        = 29;
  localparam int C_EX_BP        = 30;
  localparam int C_EX_SYS       = 31;
  localparam int C_DSRAM_EN     = 32;
  localparam int C_MUL_TO_REG   = 33;

  localparam logic REGDST_RT = 1'b0;
  localparam logic REGDST_RD = 1'b1;

  // Byte-lane masks, shared by memWrite and memReadWidth
  localparam logic [3:0] MW_NONE = 4'b0000;
  localparam logic [3:0] MW_BYTE = 4'b0001;
  localparam logic [3:0] MW_HALF = 4'b0011;
  localparam logic [3:0] MW_WORD = 4'b1111;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0a;
  localparam logic [5:0] OP_SLTIU    = 6'h0b;
  localparam logic [5:0] OP_ANDI     = 6'h0c;
  localparam logic [5:0] OP_ORI      = 6'h0d;
  localparam logic [5:0] OP_XORI     = 6'h0e;
  localparam logic [5:0] OP_LUI      = 6'h0f;
  localparam logic [5:0] OP_COP0     = 6'h10;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1c;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_LBU      = 6'h24;
  localparam logic [5:0] OP_LHU      = 6'h25;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SW       = 6'h2b;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_JALR = 6'h09;
  localparam logic [5:0] F_SYSCALL = 6'h0c, F_BREAK = 6'h0d, F_MFHI = 6'h10, F_MTHI = 6'h11;
  localparam logic [5:0] F_MFLO = 6'h12, F_MTLO = 6'h13, F_MULT = 6'h18, F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV = 6'h1a, F_DIVU = 6'h1b, F_ADD = 6'h20, F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2a, F_SLTU = 6'h2b;
  localparam logic [5:0] F2_MUL = 6'h02;

  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;
  localparam logic [4:0] RS_MFC0 = 5'h00, RS_MTC0 = 5'h04;

  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

endpackage

// File: rtl/decode_queue_if.sv
// rtl/decode_queue_if.sv - fetch-side and execute-side valid/ready bundle of decode_queue
interface decode_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  logic                        in_valid;
  logic                        in_ready;
  logic [31:0]                 in_inst;
  logic [PC_W-1:0]             in_pc;
  logic                        out_valid;
  logic                        out_ready;
  logic [31:0]                 out_inst;
  logic [PC_W-1:0]             out_pc;
  logic [decode_pkg::CTRL_W-1:0] out_ctrl;
  logic                        out_is_ds;
  logic [CNT_W-1:0]            count;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_ctrl, out_is_ds, count
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_ctrl, out_is_ds, count
  );
endinterface

// File: rtl/decode_core.sv
// rtl/decode_core.sv - combinational instruction word to control word decoder
// Macro DECODE_MUL_EN enables the SPECIAL2 MUL encoding.
module decode_core
  import decode_pkg::*;
(
  input  logic [31:0]       inst,
  output logic [CTRL_W-1:0] ctrl
);
  logic [5:0] op, funct;
  logic [4:0] rs, rt;
  logic       legal;

  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign funct = inst[5:0];

  always_comb begin
    ctrl  = '0;
    legal = 1'b1;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_ADD, F_ADDU, F_SUB, F_SUBU,
          F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
            ctrl[C_REGWRITE] = 1'b1;
            ctrl[C_REGDST]   = REGDST_RD;
          end
          F_JR: ctrl[C_JR] = 1'b1;
          F_JALR: begin
            ctrl[C_JR]       = 1'b1;
            ctrl[C_JALR]     = 1'b1;
            ctrl[C_REGWRITE] = 1'b1;
            ctrl[C_REGDST]   = REGDST_RD;
          end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            ctrl[C_HILOWRITE] = 1'b1;
            ctrl[C_MDTOHILO]  = 1'b1;
            ctrl[C_MULORDIV]  = ~funct[1];
            ctrl[C_MDSIGN]    = ~funct[0];
          end
          F_MFHI, F_MFLO: begin
            ctrl[C_REGWRITE]  = 1'b1;
            ctrl[C_REGDST]    = REGDST_RD;
            ctrl[C_HILOTOREG] = 1'b1;
            ctrl[C_HILOSRC]   = ~funct[1];
          end
          F_MTHI: begin
            ctrl[C_HILOWRITE]    = 1'b1;
            ctrl[C_REGTOHILO_HI] = 1'b1;
          end
          F_MTLO: begin
            ctrl[C_HILOWRITE]    = 1'b1;
            ctrl[C_REGTOHILO_LO] = 1'b1;
          end
          F_SYSCALL: ctrl[C_EX_SYS] = 1'b1;
          F_BREAK:   ctrl[C_EX_BP]  = 1'b1;
          default:   legal = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: ctrl[C_BRANCH] = 1'b1;
          RT_BLTZAL, RT_BGEZAL: begin
            ctrl[C_BRANCH]   = 1'b1;
            ctrl[C_BAL]      = 1'b1;
            ctrl[C_REGWRITE] = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_J: ctrl[C_JUMP] = 1'b1;
      OP_JAL: begin
        ctrl[C_JUMP]     = 1'b1;
        ctrl[C_JAL]      = 1'b1;
        ctrl[C_REGWRITE] = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: ctrl[C_BRANCH] = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl[C_REGWRITE] = 1'b1;
        ctrl[C_ALUSRC]   = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        ctrl[C_REGWRITE]  = 1'b1;
        ctrl[C_ALUSRC]    = 1'b1;
        ctrl[C_MEMTOREG]  = 1'b1;
        ctrl[C_DSRAM_EN]  = 1'b1;
        ctrl[C_MEMSIGN]   = ~op[2];
        ctrl[C_MEMREAD_MSB:C_MEMREAD_LSB] = (op[1:0] == 2'b00) ? MW_BYTE :
                                            (op[1:0] == 2'b01) ? MW_HALF : MW_WORD;
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl[C_ALUSRC]   = 1'b1;
        ctrl[C_DSRAM_EN] = 1'b1;
        ctrl[C_MEMWRITE_MSB:C_MEMWRITE_LSB] = (op[1:0] == 2'b00) ? MW_BYTE :
                                              (op[1:0] == 2'b01) ? MW_HALF : MW_WORD;
      end
      OP_COP0: begin
        if (inst != ERET_WORD) begin
          case (rs)
            RS_MFC0: begin
              ctrl[C_REGWRITE] = 1'b1;
              ctrl[C_CP0TOREG] = 1'b1;
            end
            RS_MTC0: ctrl[C_WRITECP0] = 1'b1;
            default: legal = 1'b0;
          endcase
        end
      end
`ifdef DECODE_MUL_EN
      OP_SPECIAL2: begin
        if (funct == F2_MUL) begin
          ctrl[C_REGWRITE]   = 1'b1;
          ctrl[C_REGDST]     = REGDST_RD;
          ctrl[C_MDSIGN]     = 1'b1;
          ctrl[C_MUL_TO_REG] = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
`else
      OP_SPECIAL2: legal = 1'b0;
`endif
      default: legal = 1'b0;
    endcase
    // Reserved instructions carry only the exception flag so nothing downstream writes
    if (!legal) begin
      ctrl          = '0;
      ctrl[C_EX_RI] = 1'b1;
    end
  end
endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - instruction queue with registered decode stage and delay-slot tagging
// Macro DECODE_MUL_EN (in decode_core) enables the SPECIAL2 MUL encoding.
module decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           flush,
  decode_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]       mem_inst_q [DEPTH];
  logic [31:0]       mem_inst_d [DEPTH];
  logic [PC_W-1:0]   mem_pc_q   [DEPTH];
  logic [PC_W-1:0]   mem_pc_d   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_inst_q, out_inst_d;
  logic [PC_W-1:0]   out_pc_q, out_pc_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
  logic              out_is_ds_q, out_is_ds_d;
  logic              ds_pending_q, ds_pending_d;
  logic [CTRL_W-1:0] head_ctrl;
  logic              push, load;

  decode_core u_core (
    .inst (mem_inst_q[rd_ptr_q]),
    .ctrl (head_ctrl)
  );

  assign bus.in_ready  = (count_q != CNT_W'(DEPTH));
  assign push          = bus.in_valid & bus.in_ready & ~flush;
  assign load          = (count_q != '0) & (~out_valid_q | bus.out_ready) & ~flush;

  assign bus.out_valid = out_valid_q;
  assign bus.out_inst  = out_inst_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.out_ctrl  = out_ctrl_q;
  assign bus.out_is_ds = out_is_ds_q;
  assign bus.count     = count_q;

  always_comb begin
    mem_inst_d   = mem_inst_q;
    mem_pc_d     = mem_pc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_inst_d   = out_inst_q;
    out_pc_d     = out_pc_q;
    out_ctrl_d   = out_ctrl_q;
    out_is_ds_d  = out_is_ds_q;
    ds_pending_d = ds_pending_q;
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      out_valid_d  = 1'b0;
      out_is_ds_d  = 1'b0;
      ds_pending_d = 1'b0;
    end else begin
      if (push) begin
        mem_inst_d[wr_ptr_q] = bus.in_inst;
        mem_pc_d[wr_ptr_q]   = bus.in_pc;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(load);
      // The delay-slot tag follows whichever instruction was loaded before this one
      if (load) begin
        rd_ptr_d     = rd_ptr_q + PTR_W'(1);
        out_valid_d  = 1'b1;
        out_inst_d   = mem_inst_q[rd_ptr_q];
        out_pc_d     = mem_pc_q[rd_ptr_q];
        out_ctrl_d   = head_ctrl;
        out_is_ds_d  = ds_pending_q;
        ds_pending_d = head_ctrl[C_BRANCH] | head_ctrl[C_JUMP] | head_ctrl[C_JR];
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_inst_q <= mem_inst_d;
    mem_pc_q   <= mem_pc_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_inst_q   <= '0;
      out_pc_q     <= '0;
      out_ctrl_q   <= '0;
      out_is_ds_q  <= 1'b0;
      ds_pending_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_inst_q   <= out_inst_d;
      out_pc_q     <= out_pc_d;
      out_ctrl_q   <= out_ctrl_d;
      out_is_ds_q  <= out_is_ds_d;
      ds_pending_q <= ds_pending_d;
    end
  end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the main decoder: a DEPTH-entry instruction queue placed between fetch and execute.
- Each queued instruction is decoded into a packed control word and held in a registered output stage.
- Interfaces on both sides use a valid/ready handshake.
- Adds synchronous flush, delay-slot tagging and full-control-word registration, none of which the combinational decoder has.

Parameters:
- DEPTH, 4: queue entries; power of two, minimum 2.
- PC_W, 32: PC width.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discards queue and output stage (exception/eret).
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  queue can accept.
- in_inst  in  32  instruction word.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts bundle.
- out_inst  out  32  registered instruction.
- out_pc  out  PC_W  registered PC.
- out_ctrl  out  CTRL_W  packed control word (package bit positions).
- out_is_ds  out  1  instruction sits in a branch/jump delay slot.
- count  out  CNT_W  current queue occupancy.

Behaviour:
- Reset (resetn=0, asynchronous): pointers=0, count=0, out_valid=0, out_inst=0, out_pc=0, out_ctrl=0, out_is_ds=0, ds_pending=0.
- Push:
  - in_ready = (count != DEPTH), registered-free combinational from count.
  - Push occurs when in_valid & in_ready & !flush; wr_ptr wraps modulo DEPTH.
  - When the queue is full, a pop in the same cycle does NOT enable a push (no full-pass-through).
- Load of the output stage:
  - load = (count != 0) & (!out_valid | out_ready) & !flush.
  - On load, the head entry is decoded combinationally and out_inst/out_pc/out_ctrl are registered; rd_ptr advances; out_valid=1.
  - If out_valid & out_ready & count==0, out_valid clears.
  - Simultaneous push and load leaves count unchanged.
- Latency: an instruction pushed at edge N reaches out_valid at edge N+1 when the queue was empty and out_ready=1. Throughput is 1 per cycle.
- Empty queue: load is blocked; the output holds its value until out_ready drains it.
- out_ready=0 with out_valid=1: the output registers hold stable; the queue continues filling until full.
- Delay-slot tagging:
  - ds_pending is set on a load whose ctrl has branch|jump|jr set, and cleared on the next load.
  - out_is_ds is registered with each load as the ds_pending value before that load.
- Flush (highest priority, synchronous):
  - Next edge: count=0, pointers=0, out_valid=0, ds_pending=0, out_is_ds=0.
  - A concurrent in_valid is dropped.
  - out_inst/out_pc/out_ctrl hold their values; they are don't-care while invalid.
- Decode rules:
  - Identical field semantics to the existing main decoder: regwrite, regdst, alusrc, branch, bal, jal, jr, jalr, jump, memWrite[3:0], memReadWidth[3:0], memLoadIsSign, memToReg, hilowrite, regToHilo_hi/lo, mdToHilo, mulOrdiv, mdIsSign, hiloToReg, hilosrc, isWritecp0, cp0ToReg, ex_ri, ex_bp, ex_sys, data_sram_en.
  - ERET (0x42000018) is a valid instruction: ex_ri=0.
  - All other unlisted encodings set ex_ri=1 with every write/mem enable forced to 0.
- Reset mid-operation: immediate clear; no partial state survives.

Optional Feature:
- Macro DECODE_MUL_EN.
- Defined: SPECIAL2 MUL (op 6'b011100, funct 6'b000010) decodes with regwrite=1, regdst=RD, mdIsSign=1, new ctrl bit mul_to_reg=1, ex_ri=0.
- Undefined: that encoding yields ex_ri=1; the mul_to_reg bit stays in the package and is tied to 0.

Decomposition:
- Package decode_pkg holds:
  - Opcode/funct/rt/rs constants.
  - CTRL_W and named bit indices/slices for every out_ctrl field.
  - memWrite/memReadWidth encodings.
  - ERET word.
- Sub-module decode_core: purely combinational, inst -> ctrl word; it is instantiated once on the queue head.
- Queue storage, pointers, output stage and delay-slot logic live in decode_queue.

Test Plan:
- Reset then push ADDU (0x00851021) with out_ready=1 -> next cycle out_valid=1, ctrl.regwrite=1, regdst=RD, ex_ri=0, count=0.
- Push 5 instructions back-to-back with out_ready=0, DEPTH=4 -> in_ready=0 after 4 accepted into the queue plus 1 in the output stage; 6th held; release out_ready -> all 5 emerge in order, PCs 0x0,4,8,C,10.
- Push BEQ then SW -> SW bundle has out_is_ds=1, memWrite=4'b1111, data_sram_en=1; following instruction has out_is_ds=0.
- With 3 queued, assert flush while in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1; flushed words never appear.
- Push 0x42000018 then 0xFC000000 -> first ex_ri=0; second ex_ri=1, regwrite=0, memWrite=0.
- Push 0x70851002 -> with DECODE_MUL_EN: regwrite=1, ex_ri=0, mul_to_reg=1; without it: ex_ri=1, regwrite=0.
